// File: rtl/ldpc_pkg.sv
// Shared definitions for the streaming LDPC encoder: FSM encoding,
// a constant-safe clog2 and the generator-row slicing helper that the
// decoder also uses.
package ldpc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } ldpc_state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

  // Bit offset of generator row `row` when every row is `m` bits wide.
  function automatic int row_base(input int row, input int m);
    return row * m;
  endfunction

endpackage

// File: rtl/ldpc_parity_chunk.sv
// Combinational partial parity of P info bits against their P generator rows.
module ldpc_parity_chunk
  import ldpc_pkg::*;
#(
  parameter int P = 6,
  parameter int M = 5
) (
  input  logic [P-1:0]   info_chunk,
  input  logic [P*M-1:0] gen_chunk,
  output logic [M-1:0]   parity_part
);

  // XOR together the generator rows selected by the set info bits.
  always_comb begin
    parity_part = '0;
    for (int i = 0; i < P; i++) begin
      if (info_chunk[i]) begin
        parity_part = parity_part ^ gen_chunk[row_base(i, M) +: M];
      end
    end
  end

endmodule

// File: rtl/ldpc_encode_stream.sv
// Streaming systematic LDPC encoder: accepts K info bits, accumulates the
// N-K parity bits over K/P cycles and presents {info, parity} on a
// valid/ready output held under backpressure.
// Optional build macro LDPC_ENC_CNT_EN adds the cw_count handshake counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for an info word, in_ready high while enabled
// ST_ACCUM | folding one P-row chunk of the generator into parity per cycle
// ST_DONE  | codeword valid and held until the sink takes it
module ldpc_encode_stream
  import ldpc_pkg::*;
#(
  parameter int N = 11,
  parameter int K = 6,
  parameter int P = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [K*(N-K)-1:0] generator_p,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K-1:0]       info_bits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       codeword,
`ifdef LDPC_ENC_CNT_EN
  output logic [15:0]        cw_count,
`endif
  output logic               busy
);

  localparam int M      = N - K;
  localparam int NCHUNK = K / P;
  localparam int CNT_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  ldpc_state_t      state, state_nxt;
  logic [K-1:0]     info_q;
  logic [M-1:0]     parity_q;
  logic [M-1:0]     parity_part;
  logic [CNT_W-1:0] cnt_q;
  logic [P-1:0]     info_chunk;
  logic [P*M-1:0]   gen_chunk;
  logic             accept;
  logic             deliver;
  logic             last_chunk;

  // Select the info bits and generator rows of the chunk being processed.
  always_comb begin
    info_chunk = info_q[int'(cnt_q) * P +: P];
    gen_chunk  = generator_p[row_base(int'(cnt_q) * P, M) +: P*M];
  end

  ldpc_parity_chunk #(
    .P (P),
    .M (M)
  ) u_chunk (
    .info_chunk  (info_chunk),
    .gen_chunk   (gen_chunk),
    .parity_part (parity_part)
  );

  // Next-state and handshake decode; out_ready reaches in_ready only in DONE.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    deliver    = 1'b0;
    last_chunk = (cnt_q == LAST_CHUNK);
    case (state)
      ST_IDLE: begin
        in_ready = i_en;
        accept   = in_valid && i_en;
        if (accept) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (i_en && last_chunk) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        in_ready = i_en && out_ready;
        deliver  = i_en && out_ready;
        accept   = deliver && in_valid;
        if (deliver) state_nxt = accept ? ST_ACCUM : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; transitions are already gated by i_en.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Info capture, parity accumulation and codeword latch on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      info_q   <= '0;
      parity_q <= '0;
      cnt_q    <= '0;
      codeword <= '0;
    end else if (accept) begin
      info_q   <= info_bits;
      parity_q <= '0;
      cnt_q    <= '0;
    end else if (state == ST_ACCUM && i_en) begin
      parity_q <= parity_q ^ parity_part;
      cnt_q    <= last_chunk ? '0 : cnt_q + 1'b1;
      if (last_chunk) codeword <= {info_q, parity_q ^ parity_part};
    end
  end

  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

`ifdef LDPC_ENC_CNT_EN
  // Count delivered codewords, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)          cw_count <= '0;
    else if (deliver) cw_count <= cw_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ldpc_encode_stream.sv
// Scoreboard bench for ldpc_encode_stream: three encoders (P=6, P=2, P=1)
// exercised one after another; expected codewords come from a direct
// bit-count parity model and are checked by an independent monitor.
module tb_ldpc_encode_stream;

  localparam int N   = 11;
  localparam int K   = 6;
  localparam int M   = N - K;
  localparam int PV0 = 6;
  localparam int PV1 = 2;
  localparam int PV2 = 1;
  localparam logic [K*M-1:0] G_TP = 30'b101001001010001011000101001001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]     rst, i_en, in_valid, in_ready, out_valid, out_ready, busy;
  logic [K-1:0]   info_bits [3];
  logic [N-1:0]   codeword  [3];
  logic [K*M-1:0] gen;
`ifdef LDPC_ENC_CNT_EN
  logic [15:0]    cw_count  [3];
`endif
  int             hs_cnt    [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]   lane;
    logic [N-1:0] cw;
  } exp_t;
  exp_t exp_q[$];
  exp_t exp_e;

  ldpc_encode_stream #(.N(N), .K(K), .P(PV0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .i_en(i_en[0]), .generator_p(gen),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .info_bits(info_bits[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .codeword(codeword[0]),
`ifdef LDPC_ENC_CNT_EN
    .cw_count(cw_count[0]),
`endif
    .busy(busy[0]));

  ldpc_encode_stream #(.N(N), .K(K), .P(PV1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .i_en(i_en[1]), .generator_p(gen),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .info_bits(info_bits[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .codeword(codeword[1]),
`ifdef LDPC_ENC_CNT_EN
    .cw_count(cw_count[1]),
`endif
    .busy(busy[1]));

  ldpc_encode_stream #(.N(N), .K(K), .P(PV2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .i_en(i_en[2]), .generator_p(gen),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .info_bits(info_bits[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .codeword(codeword[2]),
`ifdef LDPC_ENC_CNT_EN
    .cw_count(cw_count[2]),
`endif
    .busy(busy[2]));

  // Reference: parity bit j is the count of set info bits whose row has bit j, mod 2.
  function automatic logic [N-1:0] ref_cw(input logic [K-1:0] info, input logic [K*M-1:0] g);
    logic [M-1:0] par;
    int s;
    par = '0;
    for (int j = 0; j < M; j++) begin
      s = 0;
      for (int i = 0; i < K; i++) begin
        if (info[i] == 1'b1 && g[i*M+j] == 1'b1) s = s + 1;
      end
      par[j] = ((s % 2) == 1);
    end
    return {info, par};
  endfunction

  function automatic int lat(input int ln);
    case (ln)
      0:       return K / PV0;
      1:       return K / PV1;
      default: return K / PV2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ln);
    rst[ln] = 1'b1;
    tick();
    tick();
    rst[ln] = 1'b0;
    #1;
    check("rst_out_valid", out_valid[ln], 0);
    check("rst_in_ready", in_ready[ln], 1);
    check("rst_codeword", codeword[ln], 0);
    check("rst_busy", busy[ln], 0);
  endtask

  // Offer one word, optionally record its expected codeword and wait for out_valid,
  // holding i_en low for stall_len cycles starting stall_at cycles into ACCUM.
  task automatic send(input int ln, input logic [K-1:0] info, input bit push,
                      input bit wait_out, input int stall_at, input int stall_len);
    int n;
    in_valid[ln]  = 1'b1;
    info_bits[ln] = info;
    #1;
    n = 0;
    while (!in_ready[ln] && n < 50) begin
      tick();
      n++;
    end
    check("accept_timeout", (n < 50), 1);
    tick();
    in_valid[ln] = 1'b0;
    if (push) begin
      exp_e.lane = 2'(ln);
      exp_e.cw   = ref_cw(info, gen);
      exp_q.push_back(exp_e);
    end
    if (wait_out) begin
      n = 0;
      while (!out_valid[ln] && n < 50) begin
        i_en[ln] = !(n >= stall_at && n < stall_at + stall_len);
        tick();
        if (!i_en[ln]) begin
          check("stall_busy", busy[ln], 1);
          check("stall_out_valid", out_valid[ln], 0);
        end
        n++;
      end
      i_en[ln] = 1'b1;
      check("latency", n, lat(ln) + stall_len);
    end
  endtask

  task automatic rand_words(input int ln, input int count);
    bit rdy;
    for (int w = 0; w < count; w++) begin
      gen = (K*M)'($urandom);
      rdy = 1'($urandom_range(0, 1));
      out_ready[ln] = rdy;
      send(ln, K'($urandom), 1, 1, $urandom_range(0, lat(ln) - 1), $urandom_range(0, 2));
      if (!rdy) repeat ($urandom_range(0, 3)) tick();
      out_ready[ln] = 1'b1;
      tick();
    end
    tick();
  endtask

  // Monitor: pop and compare on every output handshake; check hold under backpressure.
  logic [2:0]   hold;
  logic [N-1:0] held_cw [3];
  initial hold = '0;

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (hold[l]) begin
        check("hold_out_valid", out_valid[l], 1);
        check("hold_codeword", codeword[l], held_cw[l]);
      end
      if (rst[l]) begin
        hs_cnt[l] <= 0;
      end else if (out_valid[l] && out_ready[l] && i_en[l]) begin
        hs_cnt[l] <= hs_cnt[l] + 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: lane %0d codeword %b with nothing expected", l, codeword[l]);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_lane", l, exp_e.lane);
          check("codeword", codeword[l], exp_e.cw);
        end
      end
      hold[l]    <= !rst[l] && out_valid[l] && !(out_ready[l] && i_en[l]);
      held_cw[l] <= codeword[l];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = '1;
    i_en      = '1;
    in_valid  = '0;
    out_ready = '1;
    gen       = G_TP;
    for (int l = 0; l < 3; l++) begin
      info_bits[l] = '0;
      hs_cnt[l]    = 0;
    end
    tick();
    tick();
    rst = '0;
    tick();

    // Known vectors on every lane.
    for (int ln = 0; ln < 3; ln++) begin
      gen = G_TP;
      do_reset(ln);
      send(ln, 6'b111111, 1, 1, 99, 0);
      send(ln, 6'b000001, 1, 1, 99, 0);
      send(ln, 6'b100000, 1, 1, 99, 0);
      send(ln, 6'b000000, 1, 1, 99, 0);
      tick();
      tick();
`ifdef LDPC_ENC_CNT_EN
      check("cw_count_four", cw_count[ln], 4);
`endif
    end

    // P=2 lane: enable gating in IDLE, backpressure, back-to-back, reset mid-ACCUM.
    gen = G_TP;
    i_en[1] = 1'b0;
    in_valid[1] = 1'b1;
    info_bits[1] = 6'b010101;
    #1;
    check("idle_disabled_in_ready", in_ready[1], 0);
    tick();
    check("idle_disabled_no_accept", busy[1], 0);
    in_valid[1] = 1'b0;
    i_en[1] = 1'b1;
    tick();

    out_ready[1] = 1'b0;
    send(1, 6'b000001, 1, 1, 99, 0);
    repeat (5) begin
      tick();
      check("bp_out_valid", out_valid[1], 1);
      check("bp_in_ready", in_ready[1], 0);
    end
    out_ready[1] = 1'b1;
    i_en[1] = 1'b0;
    repeat (2) begin
      tick();
      check("dis_out_valid", out_valid[1], 1);
      check("dis_in_ready", in_ready[1], 0);
    end
    i_en[1] = 1'b1;
    #1;
    check("done_in_ready_follows", in_ready[1], 1);
    send(1, 6'b111111, 1, 1, 99, 0);
    tick();
    tick();

    send(1, 6'b101010, 0, 0, 99, 0);
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    #1;
    check("midrst_out_valid", out_valid[1], 0);
    check("midrst_in_ready", in_ready[1], 1);
    check("midrst_codeword", codeword[1], 0);
    check("midrst_busy", busy[1], 0);
    repeat (6) tick();
    check("midrst_no_output", out_valid[1], 0);
    rand_words(1, 20);

    // P=1 lane: enable stall mid-ACCUM, then random traffic.
    gen = G_TP;
    send(2, 6'b111111, 1, 1, 2, 3);
    tick();
    tick();
    rand_words(2, 20);
    rand_words(0, 10);

    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);
`ifdef LDPC_ENC_CNT_EN
    for (int l = 0; l < 3; l++) begin
      check("cw_count_total", cw_count[l], hs_cnt[l]);
      do_reset(l);
      check("cw_count_rst", cw_count[l], 0);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
